pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Parametrised next-generation program counter for the RV32I pipeline fetch stage.
- Adds a reset vector, prioritised trap/branch redirects, halt/resume control and a request/grant handshake towards instruction memory.
- Adds a fetch counter, and optional misaligned-target detection.
- Sits between the branch-resolution/trap logic and the instruction memory port.

Parameters:
- XLEN, 32, width of pc and all address ports.
- RESET_VECTOR, 32'h0000_0000, pc value loaded on reset.
- STEP, 4, sequential increment in bytes.
- CNT_W, 16, width of FetchCount.

Ports:
- Clk  in  1  clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Enable  in  1  pipeline advance; 0 = stall (hold pc).
- Halt  in  1  request to stop fetching.
- Resume  in  1  request to restart fetching from halt.
- BranchTaken  in  1  branch/jump redirect valid.
- BranchTarget  in  XLEN  branch/jump destination.
- TrapTaken  in  1  trap redirect valid.
- TrapVector  in  XLEN  trap handler address.
- ImemGnt  in  1  instruction memory accepted ImemAddr this cycle.
- ImemReq  out  1  fetch request valid.
- ImemAddr  out  XLEN  fetch address, always equal to pc.
- pc  out  XLEN  current program counter.
- Halted  out  1  unit is in HALT state.
- FetchCount  out  CNT_W  number of granted fetches.
- MisalignErr  out  1  misaligned redirect pulse (optional feature only).
- MisalignAddr  out  XLEN  offending target (optional feature only).

Behaviour:
- Reset is synchronous, active-high, clock Clk. On Reset=1 at a rising edge:
  - pc=RESET_VECTOR, state=BOOT, FetchCount=0.
  - ImemReq=0, Halted=0, MisalignErr=0, MisalignAddr=0.
  - Reset overrides every other input; Reset mid-operation abandons any outstanding request with no completion.
- States:
  - BOOT: exactly one cycle with ImemReq=0, then RUN unconditionally.
  - RUN: ImemReq=1.
  - HALT: ImemReq=0, Halted=1.
- Transitions:
  - RUN->HALT when Halt=1. A grant in that same cycle still completes: pc advances and the count increments.
  - HALT->RUN when Resume=1 and Halt=0. Halt wins if both are 1.
  - Halt in BOOT is taken at the BOOT->RUN edge, so the unit goes directly to HALT.
- pc next-value priority, evaluated every cycle in any state other than BOOT and reset:
  1. TrapTaken=1: pc<=TrapVector. Applies regardless of Enable, ImemGnt or HALT.
  2. BranchTaken=1: pc<=BranchTarget. Applies regardless of Enable and ImemGnt. Ignored in HALT.
  3. RUN, Enable=1 and ImemGnt=1: pc<=pc+STEP, modulo 2^XLEN (32'hFFFF_FFFC+4 -> 0).
  4. Otherwise pc holds.
- A redirect in the same cycle as a grant: the granted address is counted, and pc takes the redirect target, not pc+STEP.
- ImemAddr is combinationally equal to pc. ImemReq depends only on state.
- While ImemReq=1 and ImemGnt=0, ImemAddr stays stable unless a redirect occurs.
- FetchCount increments by 1 on each cycle with ImemReq=1 and ImemGnt=1, independent of Enable. It wraps from 2^CNT_W-1 to 0.
- A grant with Enable=0 is counted, but pc does not advance, so the same address is refetched. The stage above is responsible for this.
- Latency: a redirect asserted in cycle N appears on pc/ImemAddr in cycle N+1.

Optional Feature:
- Macro: PC_MISALIGN_CHECK_EN.
- Defined:
  - A winning redirect target with bits[1:0]!=0 is not loaded; pc holds.
  - MisalignErr=1 for exactly one cycle (N+1).
  - MisalignAddr<=target, held until the next error or reset.
  - A trap target is checked the same way.
- Not defined:
  - Targets load unmodified.
  - MisalignErr and MisalignAddr are tied to 0; the ports remain present.

Test Plan:
- Reset with RESET_VECTOR=32'h0000_1000, then ImemGnt=1, Enable=1 -> cycle 1 ImemReq=0; then pc 0x1000, 0x1004, 0x1008; FetchCount 0, 1, 2.
- ImemGnt=0 for 3 cycles at pc=0x1008 -> pc and ImemAddr stay 0x1008, FetchCount unchanged; grant -> pc 0x100C.
- TrapTaken=1 (TrapVector=0x200) and BranchTaken=1 (BranchTarget=0x80) in the same cycle as a grant -> next pc=0x200, FetchCount+1.
- Enable=0 with BranchTaken=1, target 0x40 -> next pc=0x40. Halt=1 then Resume=1 -> Halted=1 and ImemReq=0 while halted, pc held; fetch restarts at the same pc.
- pc=32'hFFFF_FFFC with a grant -> pc=0. FetchCount at 16'hFFFF with a grant -> 0.
- With PC_MISALIGN_CHECK_EN, BranchTarget=0x102 -> pc unchanged, MisalignErr pulses 1 cycle, MisalignAddr=0x102. Without the macro -> pc=0x102, MisalignErr=0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// RV32I fetch-stage program counter: reset vector, trap/branch redirects, halt/resume, imem req/gnt.
// Optional misaligned-redirect detection is enabled with `define PC_MISALIGN_CHECK_EN.
module pc_fetch_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     STEP         = 4,
  parameter int unsigned     CNT_W        = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Halt,
  input  logic             Resume,
  input  logic             BranchTaken,
  input  logic [XLEN-1:0]  BranchTarget,
  input  logic             TrapTaken,
  input  logic [XLEN-1:0]  TrapVector,
  input  logic             ImemGnt,
  output logic             ImemReq,
  output logic [XLEN-1:0]  ImemAddr,
  output logic [XLEN-1:0]  pc,
  output logic             Halted,
  output logic [CNT_W-1:0] FetchCount,
  output logic             MisalignErr,
  output logic [XLEN-1:0]  MisalignAddr
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              halted_q, halted_d;
  logic              redir_c;
  logic [XLEN-1:0]   target_c;

`ifdef PC_MISALIGN_CHECK_EN
  logic              merr_q, merr_d;
  logic [XLEN-1:0]   maddr_q, maddr_d;
`endif

  // Winning redirect: trap beats branch; branches are ignored while halted.
  always_comb begin
    redir_c  = 1'b0;
    target_c = BranchTarget;
    if (state_q != ST_BOOT) begin
      if (TrapTaken) begin
        redir_c  = 1'b1;
        target_c = TrapVector;
      end else if (BranchTaken && (state_q != ST_HALT)) begin
        redir_c  = 1'b1;
        target_c = BranchTarget;
      end
    end
  end

  // Next state, pc, counter and status.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
`ifdef PC_MISALIGN_CHECK_EN
    merr_d  = 1'b0;
    maddr_d = maddr_q;
`endif

    unique case (state_q)
      ST_BOOT: state_d = Halt ? ST_HALT : ST_RUN;
      ST_RUN:  state_d = Halt ? ST_HALT : ST_RUN;
      ST_HALT: state_d = (Resume && !Halt) ? ST_RUN : ST_HALT;
      default: state_d = ST_BOOT;
    endcase

    if (req_q && ImemGnt) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (redir_c) begin
`ifdef PC_MISALIGN_CHECK_EN
      if (target_c[1:0] != 2'b00) begin
        merr_d  = 1'b1;
        maddr_d = target_c;
      end else begin
        pc_d = target_c;
      end
`else
      pc_d = target_c;
`endif
    end else if ((state_q == ST_RUN) && Enable && ImemGnt) begin
      pc_d = pc_q + XLEN'(STEP);
    end

    req_d    = (state_d == ST_RUN);
    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_VECTOR;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      halted_q <= halted_d;
    end
  end

`ifdef PC_MISALIGN_CHECK_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      merr_q  <= 1'b0;
      maddr_q <= '0;
    end else begin
      merr_q  <= merr_d;
      maddr_q <= maddr_d;
    end
  end

  assign MisalignErr  = merr_q;
  assign MisalignAddr = maddr_q;
`else
  assign MisalignErr  = 1'b0;
  assign MisalignAddr = '0;
`endif

  assign ImemReq    = req_q;
  assign ImemAddr   = pc_q;
  assign pc         = pc_q;
  assign Halted     = halted_q;
  assign FetchCount = cnt_q;

endmodule
